// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: state encodings, default timing
// and a small constant helper used for counter sizing.
package rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_HOLD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  localparam int DEF_N_DOM    = 4;
  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_GAP_CYC  = 8;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating up-counter with clear, enable and a terminal-count compare
// against a run-time limit, so one instance serves both hold and gap intervals.
module rst_seq_timer #(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tc = (cnt_q == i_limit);

  // Next count: clear wins, otherwise count up and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q < i_limit)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets low, then releases them one per
// gap in ascending order. A 4-phase software request re-runs the sequence.
//
//  state     | meaning
//  ST_ASSERT | all resets low for one cycle, timer cleared
//  ST_HOLD   | all resets low, counting the initial hold, then release domain 0
//  ST_GAP    | counting the gap before releasing domain idx
//  ST_DONE   | all domains released, waiting for a software request
//  ST_ACK    | sw sequence finished, ack high until the request drops
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_DOM    = DEF_N_DOM,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sw_rst_req,
  output logic             o_sw_rst_ack,
  output logic [N_DOM-1:0] o_rst_n,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(max_i(HOLD_CYC, GAP_CYC) + 1);
  localparam int IDX_W = $clog2(N_DOM + 1);
  // The hold interval ends one cycle later than a gap of the same length
  // because the counter starts on the ST_ASSERT exit edge; this makes the
  // first release land at E0+1+HOLD_CYC and later ones exactly GAP_CYC apart.
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOM - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] rst_n_q, rst_n_d;
  logic             sw_q, sw_d;
  logic             ack_q, ack_d;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_lim;

  rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (tmr_clr),
    .i_en    (tmr_en),
    .i_limit (tmr_lim),
    .o_tc    (tmr_tc)
  );

  // Next-state, release and handshake decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    sw_d    = sw_q;
    ack_d   = ack_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_lim = GAP_LIM;
    case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        idx_d   = '0;
        tmr_clr = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        tmr_en  = 1'b1;
        tmr_lim = HOLD_LIM;
        if (tmr_tc) begin
          rst_n_d[0] = 1'b1;
          idx_d      = IDX_W'(1);
          tmr_clr    = 1'b1;
          if (N_DOM == 1) begin
            state_d = sw_q ? ST_ACK : ST_DONE;
            ack_d   = sw_q;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          for (int k = 0; k < N_DOM; k++) begin
            if (IDX_W'(k) == idx_q) rst_n_d[k] = 1'b1;
          end
          idx_d   = idx_q + IDX_W'(1);
          tmr_clr = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = sw_q ? ST_ACK : ST_DONE;
            ack_d   = sw_q;
          end
        end
      end
      ST_DONE: begin
        if (i_sw_rst_req) begin
          sw_d    = 1'b1;
          rst_n_d = '0;
          state_d = ST_ASSERT;
        end
      end
      ST_ACK: begin
        if (!i_sw_rst_req) begin
          ack_d   = 1'b0;
          sw_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  // State and output registers; i_rst forces a full restart from any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      rst_n_q <= '0;
      sw_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      sw_q    <= sw_d;
      ack_q   <= ack_d;
    end
  end

  // Parameter sanity, simulation only.
  always_ff @(posedge i_clk) begin
    assert (N_DOM >= 1 && HOLD_CYC >= 1 && GAP_CYC >= 1)
      else $error("rst_seq_ctrl: N_DOM, HOLD_CYC and GAP_CYC must all be >= 1");
  end

  assign o_rst_n      = rst_n_q;
  assign o_done       = &rst_n_q;
  assign o_busy       = ~(&rst_n_q);
  assign o_sw_rst_ack = ack_q;

endmodule
